mux2_rr_feeder: RTL and testbench
=================================

// Module: mux2_rr_feeder
// PURPOSE
//  Round-robin front end for the 2:1 mux stage. It arbitrates two valid/ready
//  source streams (a, b) and drives the mux select line sel (0 = a, 1 = b).
//  Each accepted beat is registered into a one-entry output stage y/y_valid/y_ready.
//  Sits directly upstream of mux2to1_new and supplies its a, b and sel inputs.
// PARAMETERS
//  WIDTH      1  data width of a, b, y (1 matches the existing mux)
//  MAX_BURST  4  max beats per grant while the other side is waiting; legal range 1..255
// PORTS
//  clk      in   1      rising-edge clock; single clock domain
//  rst      in   1      synchronous, active-high reset
//  a        in   WIDTH  source A data
//  a_valid  in   1      source A has a beat
//  a_ready  out  1      source A beat accepted this cycle when a_valid && a_ready
//  b        in   WIDTH  source B data
//  b_valid  in   1      source B has a beat
//  b_ready  out  1      source B beat accepted this cycle when b_valid && b_ready
//  sel      out  1      registered mux select: 0 = A granted, 1 = B granted
//  y        out  WIDTH  registered output data
//  y_valid  out  1      y holds a beat
//  y_ready  in   1      downstream accepts y this cycle
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE, sel=0, y=0, y_valid=0, burst_cnt=0, last=B (so A wins the first tie).
//   - Reset mid-transfer discards the held beat; y_valid=0 on the next cycle.
//  FSM states: IDLE, GRANT_A, GRANT_B. sel is 0 in GRANT_A, 1 in GRANT_B, holds in IDLE.
//  Output-register capacity:
//   - space = !y_valid || y_ready.
//   - a_ready = (state==GRANT_A) && space; b_ready = (state==GRANT_B) && space.
//   - a_ready and b_ready are never both 1.
//  Accepted beat:
//   - y and y_valid=1 are registered on the next edge (latency 1 clk).
//   - With y_ready held at 1, throughput is 1 beat/clk.
//  Hold and drain:
//   - y_valid && !y_ready: y and y_valid hold stable, and both readies are 0.
//   - y accepted with no new beat: y_valid=0 on the next edge; y keeps its last value.
//  IDLE:
//   - Only a_valid -> GRANT_A. Only b_valid -> GRANT_B.
//   - Both valid -> grant the side != last.
//   - Neither valid -> stay in IDLE.
//   - The grant takes effect on the next cycle, so the first beat leaves a source
//     2 clks after its valid rises.
//  GRANT_x (x granted, o = other side):
//   - Accepted beat: burst_cnt++.
//   - If burst_cnt reaches MAX_BURST: when o_valid, switch to GRANT_o; otherwise
//     stay in GRANT_x. burst_cnt clears to 0 in both cases.
//   - x_valid=0: release. Go to GRANT_o if o_valid, else IDLE. burst_cnt=0, last=x.
//   - x_valid=1 with no space: stay in GRANT_x; the counter does not advance.
//   - Every grant change sets last to the side that was just released.
//  Width and arithmetic:
//   - burst_cnt is 8 bits and never exceeds MAX_BURST, so there is no wrap.
//   - Data passes through unmodified; there is no arithmetic on the data path.
//  Source rules: sources must not drop valid or change data while valid && !ready.
//   A dropped valid is treated as a release.
// TESTING
//  1. Reset: hold rst 3 clks with a_valid=b_valid=1
//     -> sel=0, y=0, y_valid=0, a_ready=b_ready=0 throughout.
//  2. A alone streams a=1,0,1,1,0, y_ready=1
//     -> sel=0; y sequence 1,0,1,1,0 starting 2 clks after a_valid rises; no gaps.
//  3. Both valid continuously, MAX_BURST=4, a=0, b=1, y_ready=1
//     -> 4 beats of y=0, then 4 of y=1, and so on; sel toggles every 4 accepts.
//  4. Backpressure: y_ready=0 for 5 clks mid-stream
//     -> y and y_valid are frozen, a_ready=0, burst_cnt is unchanged,
//        and no beat is lost or duplicated after release.
//  5. B drops b_valid after 2 beats while a_valid=1
//     -> next cycle GRANT_A, sel=0; the next y beats come from A.
//  6. rst asserted while y_valid=1 and y_ready=0
//     -> next cycle y_valid=0, state IDLE, sel=0; the held beat is never delivered.

Source files
------------

// File: rtl/mux2_rr_feeder.sv
// Round-robin arbiter for two valid/ready sources feeding a 2:1 mux, with a
// one-entry registered output stage and bounded bursts per grant.
module mux2_rr_feeder #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [1:0]       dbg_state,
    output logic [7:0]       dbg_burst_cnt
);
    // Handshake: a beat moves when valid && ready on the same rising edge;
    // a source holds valid and data stable until then, and y follows the same rule.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic       SIDE_A     = 1'b0;
    localparam logic       SIDE_B     = 1'b1;

    state_t           state_q;
    logic             sel_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             y_valid_q;
    logic             y_valid_d;
    logic [7:0]       burst_cnt_q;
    logic             last_q;

    logic space;
    logic acc_a;
    logic acc_b;
    logic burst_done;

    assign space      = !y_valid_q || y_ready;
    assign a_ready    = (state_q == GRANT_A) && space;
    assign b_ready    = (state_q == GRANT_B) && space;
    assign acc_a      = a_valid && a_ready;
    assign acc_b      = b_valid && b_ready;
    assign burst_done = (burst_cnt_q == BURST_LAST);

    // The output slot reloads whenever it has room; otherwise it holds.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (space) begin
            y_valid_d = acc_a || acc_b;
            if (acc_a) begin
                y_d = a;
            end else if (acc_b) begin
                y_d = b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            burst_cnt_q <= 8'd0;
            last_q      <= SIDE_B;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            case (state_q)
                IDLE: begin
                    if (a_valid && (!b_valid || last_q == SIDE_B)) begin
                        state_q <= GRANT_A;
                        sel_q   <= 1'b0;
                    end else if (b_valid) begin
                        state_q <= GRANT_B;
                        sel_q   <= 1'b1;
                    end
                end
                GRANT_A: begin
                    if (!a_valid) begin
                        burst_cnt_q <= 8'd0;
                        last_q      <= SIDE_A;
                        if (b_valid) begin
                            state_q <= GRANT_B;
                            sel_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (acc_a) begin
                        if (burst_done) begin
                            burst_cnt_q <= 8'd0;
                            if (b_valid) begin
                                state_q <= GRANT_B;
                                sel_q   <= 1'b1;
                                last_q  <= SIDE_A;
                            end
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                        end
                    end
                end
                GRANT_B: begin
                    if (!b_valid) begin
                        burst_cnt_q <= 8'd0;
                        last_q      <= SIDE_B;
                        if (a_valid) begin
                            state_q <= GRANT_A;
                            sel_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (acc_b) begin
                        if (burst_done) begin
                            burst_cnt_q <= 8'd0;
                            if (a_valid) begin
                                state_q <= GRANT_A;
                                sel_q   <= 1'b0;
                                last_q  <= SIDE_B;
                            end
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel           = sel_q;
    assign y             = y_q;
    assign y_valid       = y_valid_q;
    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Directed bench for mux2_rr_feeder: reset, single-source streaming, round-robin
// bursts, backpressure, early release and reset while a beat is held.
module tb_mux2_rr_feeder;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GA   = 2'd1;
    localparam logic [1:0] S_GB   = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [0:0] b;
    logic       b_valid;
    logic       b_ready;
    logic       sel;
    logic [0:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] dbg_state;
    logic [7:0] dbg_burst_cnt;

    int total = 0;
    int bad   = 0;

    logic [0:0] pat2 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // clock / reset
    always #5 clk = ~clk;

    mux2_rr_feeder #(.WIDTH(1), .MAX_BURST(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .b             (b),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .sel           (sel),
        .y             (y),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .dbg_state     (dbg_state),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    // driver: advance one edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; a = 1'b1; b = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;

        // 1. reset held 3 clks with both sources valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sel", 32'(sel), 0);
            check("rst_y", 32'(y), 0);
            check("rst_yv", 32'(y_valid), 0);
            check("rst_ardy", 32'(a_ready), 0);
            check("rst_brdy", 32'(b_ready), 0);
            check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check("idle_state", 32'(dbg_state), 32'(S_IDLE));

        // 2. A streams 1,0,1,1,0 alone
        a_valid = 1'b1; a = pat2[0];
        tick();
        check("s2_grant", 32'(dbg_state), 32'(S_GA));
        check("s2_yv_lat", 32'(y_valid), 0);
        check("s2_ardy", 32'(a_ready), 1);
        for (int i = 0; i < 5; i++) begin
            a = pat2[i];
            tick();
            check("s2_y", 32'(y), 32'(pat2[i]));
            check("s2_yv", 32'(y_valid), 1);
            check("s2_sel", 32'(sel), 0);
            check("s2_cnt", 32'(dbg_burst_cnt), 32'((i + 1) % 4));
        end
        a_valid = 1'b0;
        tick();
        check("s2_drain_yv", 32'(y_valid), 0);
        check("s2_drain_y", 32'(y), 32'(pat2[4]));
        check("s2_release", 32'(dbg_state), 32'(S_IDLE));

        // 3. both valid, bursts of 4 alternate starting with A after reset
        rst = 1'b1;
        tick();
        rst = 1'b0; a = 1'b0; b = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        tick();
        check("s3_first_grant", 32'(dbg_state), 32'(S_GA));
        for (int i = 0; i < 16; i++) begin
            tick();
            check("s3_y", 32'(y), 32'((i / 4) % 2));
            check("s3_yv", 32'(y_valid), 1);
            check("s3_sel", 32'(sel), 32'(((i + 1) / 4) % 2));
            check("s3_excl", 32'(a_ready & b_ready), 0);
        end

        // 4. backpressure mid-stream from A
        b_valid = 1'b0; a = 1'b1;
        tick();
        check("s4_y0", 32'(y), 1);
        a = 1'b0;
        tick();
        check("s4_y1", 32'(y), 0);
        check("s4_cnt", 32'(dbg_burst_cnt), 2);
        a = 1'b1; y_ready = 1'b0;
        #1;
        check("s4_ardy_off", 32'(a_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s4_hold_y", 32'(y), 0);
            check("s4_hold_yv", 32'(y_valid), 1);
            check("s4_hold_cnt", 32'(dbg_burst_cnt), 2);
            check("s4_hold_ardy", 32'(a_ready), 0);
        end
        y_ready = 1'b1;
        tick();
        check("s4_resume_y", 32'(y), 1);
        check("s4_resume_cnt", 32'(dbg_burst_cnt), 3);
        a = 1'b0;
        tick();
        check("s4_last_y", 32'(y), 0);
        check("s4_wrap_cnt", 32'(dbg_burst_cnt), 0);
        check("s4_stay_a", 32'(dbg_state), 32'(S_GA));
        a_valid = 1'b0;
        tick();
        check("s4_no_dup", 32'(y_valid), 0);
        check("s4_idle", 32'(dbg_state), 32'(S_IDLE));

        // 5. last=A, so B wins the tie; B drops after 2 beats
        a = 1'b0; b = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        tick();
        check("s5_grant_b", 32'(dbg_state), 32'(S_GB));
        check("s5_sel_b", 32'(sel), 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("s5_b_y", 32'(y), 1);
            check("s5_b_yv", 32'(y_valid), 1);
        end
        b_valid = 1'b0;
        tick();
        check("s5_switch", 32'(dbg_state), 32'(S_GA));
        check("s5_sel_a", 32'(sel), 0);
        check("s5_gap", 32'(y_valid), 0);
        tick();
        check("s5_a_y", 32'(y), 0);
        check("s5_a_yv", 32'(y_valid), 1);

        // 6. reset while a beat is held
        y_ready = 1'b0; a = 1'b1;
        tick();
        check("s6_held", 32'(y_valid), 1);
        rst = 1'b1;
        tick();
        check("s6_yv", 32'(y_valid), 0);
        check("s6_state", 32'(dbg_state), 32'(S_IDLE));
        check("s6_sel", 32'(sel), 0);
        rst = 1'b0; a_valid = 1'b0; y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_lost", 32'(y_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
